// File: rtl/param_reg_file_pkg.sv
// ----------------------------------------------------------------------------
// param_reg_file_pkg
// Shared definitions for the register file and its neighbours in the datapath
// (decode drives read addresses and busy marking, writeback drives the write
// port). Holds the default geometry, the register-index and data-word types
// at that geometry, and the index of the hardwired zero register.
// ----------------------------------------------------------------------------
package param_reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);

  typedef logic [DEF_AW-1:0]    reg_idx_t;
  typedef logic [DEF_WIDTH-1:0] word_t;

  localparam int unsigned ZERO_IDX = 0;

endpackage

// File: rtl/param_reg_file_reg_word.sv
// ----------------------------------------------------------------------------
// reg_word
// One WIDTH-bit storage word: a bank of D flip-flops with a shared load
// enable and synchronous active-high clear.
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high clear
//   we   in   load enable
//   d    in   WIDTH  data to load
//   q    out  WIDTH  stored value
// ----------------------------------------------------------------------------
module reg_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (we) word_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign q = word_q;

endmodule

// File: rtl/param_reg_file.sv
// ----------------------------------------------------------------------------
// param_reg_file
// Parametrised register file with muxed combinational read ports, a single
// write port and a per-register busy scoreboard used by decode to stall on
// registers with an outstanding producer.
//
// Optional feature (compile-time macro PARAM_REG_FILE_BYPASS_EN):
//   defined   -> a read matching the active write address returns wr_data in
//                the same cycle; its busy flag reflects the clear-by-write
//                unless busy_set re-marks the same register that cycle.
//   undefined -> reads see stored state only.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (data and busy bits)
//   wr_en      in   writeback strobe
//   wr_addr    in   AW          writeback register index
//   wr_data    in   WIDTH       writeback data
//   busy_set   in   mark busy_addr as having a pending producer
//   busy_addr  in   AW          register to mark busy
//   rd_addr    in   NUM_RD*AW   packed read addresses, port i at [i*AW +: AW]
//   rd_data    out  NUM_RD*WIDTH packed read data
//   rd_busy    out  NUM_RD      busy flag of each addressed register
//   any_busy   out  OR of all busy bits
// ----------------------------------------------------------------------------
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  // Derived from DEPTH; leave at its default.
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    busy_set,
  input  logic [AW-1:0]           busy_addr,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic                    any_busy
);

  localparam logic [AW-1:0] ZADDR = AW'(ZERO_IDX);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            busy_q;
  logic [DEPTH-1:0]            busy_d;

  // Storage words; the zero register, when enabled, is a constant.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    if (ZERO_REG != 0 && g == 0) begin : g_zero
      assign mem[g] = '0;
    end else begin : g_reg
      logic we;
      assign we = wr_en && (wr_addr == AW'(g));
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .d   (wr_data),
        .q   (mem[g])
      );
    end
  end

  // Writeback clears first, then busy_set re-marks: a newer producer issued
  // in the same cycle as the older one's writeback keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)    busy_d[wr_addr]   = 1'b0;
    if (busy_set) busy_d[busy_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] rword;
  logic             rbsy;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rword   = '0;
    rbsy    = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra    = rd_addr[i*AW +: AW];
      rword = mem[ra];
      rbsy  = busy_q[ra];
`ifdef PARAM_REG_FILE_BYPASS_EN
      if (wr_en && (ra == wr_addr)) begin
        rword = wr_data;
        rbsy  = busy_set && (busy_addr == ra);
      end
`endif
      // Zero register overrides everything, including the bypass path.
      if (ZERO_REG != 0 && ra == ZADDR) begin
        rword = '0;
        rbsy  = 1'b0;
      end
      rd_data[i*WIDTH +: WIDTH] = rword;
      rd_busy[i]                = rbsy;
    end
  end

  assign any_busy = |busy_q;

endmodule

// File: tb/tb_param_reg_file.sv
module tb_param_reg_file;
  import param_reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  reg_idx_t    wr_addr;
  word_t       wr_data;
  logic        busy_set;
  reg_idx_t    busy_addr;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        any_busy;
  logic [31:0] z0_rd_data;
  logic [1:0]  z0_rd_busy;
  logic        z0_any_busy;

  int errs   = 0;
  int checks = 0;

`ifdef PARAM_REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  param_reg_file #(.NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .any_busy(any_busy)
  );

  param_reg_file #(.NUM_RD(2), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr), .rd_addr(rd_addr),
    .rd_data(z0_rd_data), .rd_busy(z0_rd_busy), .any_busy(z0_any_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; busy_set = 1'b0;
  endtask

  task automatic set_rd(input reg_idx_t a0, input reg_idx_t a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_addr = '0; rd_addr = '0;
    step();
    idle();
    set_rd(4'd5, 4'd7);
    #1;
    check_val("init_rd5", {16'h0, rd_data[15:0]}, 32'h0);
    check_val("init_any_busy", {31'h0, any_busy}, 32'h0);

    // Reset clears data and busy bits
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    step(); idle();
    busy_set = 1'b1; busy_addr = 4'd7;
    step(); idle();
    check_val("pre_rst_rd5", {16'h0, rd_data[15:0]}, 32'hBEEF);
    check_val("pre_rst_busy7", {31'h0, rd_busy[1]}, 32'h1);
    rst = 1'b1;
    step(); idle();
    check_val("rst_rd5", {16'h0, rd_data[15:0]}, 32'h0);
    check_val("rst_busy7", {31'h0, rd_busy[1]}, 32'h0);
    check_val("rst_any_busy", {31'h0, any_busy}, 32'h0);

    // Write then read on both ports
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    set_rd(4'd3, 4'd3);
    #1;
    check_val("wr_lat_old", {16'h0, rd_data[15:0]}, BYP ? 32'h1234 : 32'h0);
    step(); idle();
    check_val("rd3_p0", {16'h0, rd_data[15:0]}, 32'h1234);
    check_val("rd3_p1", {16'h0, rd_data[31:16]}, 32'h1234);

    // Same-cycle read during write
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hAAAA;
    #1;
    check_val("rdw_p0", {16'h0, rd_data[15:0]}, BYP ? 32'hAAAA : 32'h1234);
    check_val("rdw_p1", {16'h0, rd_data[31:16]}, BYP ? 32'hAAAA : 32'h1234);
    step(); idle();
    check_val("rdw_after", {16'h0, rd_data[15:0]}, 32'hAAAA);

    // Scoreboard: set, clear by write
    busy_set = 1'b1; busy_addr = 4'd9;
    set_rd(4'd9, 4'd3);
    step(); idle();
    check_val("busy9_set", {31'h0, rd_busy[0]}, 32'h1);
    check_val("busy3_clear", {31'h0, rd_busy[1]}, 32'h0);
    check_val("busy9_any", {31'h0, any_busy}, 32'h1);
    // repeated set, no counting
    busy_set = 1'b1; busy_addr = 4'd9;
    step(); idle();
    check_val("busy9_reset_twice", {31'h0, rd_busy[0]}, 32'h1);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0042;
    step(); idle();
    check_val("busy9_cleared", {31'h0, rd_busy[0]}, 32'h0);
    check_val("busy9_any_clr", {31'h0, any_busy}, 32'h0);
    check_val("rd9_0042", {16'h0, rd_data[15:0]}, 32'h0042);

    // busy_set and write same register, same cycle: set wins
    busy_set = 1'b1; busy_addr = 4'd9;
    step(); idle();
    busy_set = 1'b1; busy_addr = 4'd9;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0077;
    #1;
    check_val("setwr_byp_busy", {31'h0, rd_busy[0]}, 32'h1);
    step(); idle();
    check_val("setwr_busy", {31'h0, rd_busy[0]}, 32'h1);
    check_val("setwr_data", {16'h0, rd_data[15:0]}, 32'h0077);
    check_val("setwr_any", {31'h0, any_busy}, 32'h1);
    // write without busy_set on a busy register
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0078;
    #1;
    check_val("wr_busy_byp", {31'h0, rd_busy[0]}, BYP ? 32'h0 : 32'h1);
    step(); idle();
    check_val("wr_busy_clr", {31'h0, rd_busy[0]}, 32'h0);
    check_val("wr_busy_data", {16'h0, rd_data[15:0]}, 32'h0078);

    // Zero register
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    busy_set = 1'b1; busy_addr = 4'd0;
    set_rd(4'd0, 4'd0);
    #1;
    check_val("zr_same_cycle", {16'h0, rd_data[15:0]}, 32'h0);
    step(); idle();
    check_val("zr_rd0", {16'h0, rd_data[15:0]}, 32'h0);
    check_val("zr_busy0", {31'h0, rd_busy[0]}, 32'h0);
    check_val("zr_any", {31'h0, any_busy}, 32'h0);
    check_val("z0_rd0", {16'h0, z0_rd_data[15:0]}, 32'hFFFF);
    check_val("z0_busy0", {31'h0, z0_rd_busy[0]}, 32'h1);

    // Reset dominates a simultaneous write and busy_set
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h1111;
    set_rd(4'd2, 4'd3);
    step(); idle();
    check_val("rd2_1111", {16'h0, rd_data[15:0]}, 32'h1111);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
    busy_set = 1'b1; busy_addr = 4'd2;
    step(); idle();
    check_val("rstdom_rd2", {16'h0, rd_data[15:0]}, 32'h0);
    check_val("rstdom_busy2", {31'h0, rd_busy[0]}, 32'h0);
    check_val("rstdom_any", {31'h0, any_busy}, 32'h0);
    check_val("rstdom_rd3", {16'h0, rd_data[31:16]}, 32'h0);

    // Independent ports on different registers
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222;
    step();
    wr_addr = 4'd15; wr_data = 16'hC3C3;
    step(); idle();
    set_rd(4'd15, 4'd2);
    #1;
    check_val("indep_p0", {16'h0, rd_data[15:0]}, 32'hC3C3);
    check_val("indep_p1", {16'h0, rd_data[31:16]}, 32'h2222);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
